// File: rtl/audio_pwm_out_if.sv
// audio_pwm_out_if: valid/ready sample stream into the PWM output stage
interface audio_pwm_out_if #(parameter int SAMPLE_W = 8);
  logic [SAMPLE_W-1:0] s_data;
  logic s_valid;
  logic s_ready;
  modport master(output s_data, s_valid, input s_ready);
  modport slave(input s_data, s_valid, output s_ready);
endinterface

// File: rtl/audio_pwm_out.sv
// audio_pwm_out: sample FIFO feeding a fixed-period PWM driver for the board amplifier
module audio_pwm_out #(
  parameter int SAMPLE_W = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int REPEAT = 1
) (
  input  logic HCLK,
  input  logic HRESET,
  input  logic enable,
  audio_pwm_out_if.slave s,
  input  logic underrun_clr,
  output logic underrun,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output wire  AUD_PWM,
  output logic AUD_SD
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int RW = REPEAT > 1 ? $clog2(REPEAT) : 1;
  logic [SAMPLE_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [SAMPLE_W-1:0] cnt, duty;
  logic [RW-1:0] rep_cnt;
  logic ready, pwm_lvl, push, pop, due, frame_end, empty;
  logic [LW-1:0] next_level;
  assign push = s.s_valid && ready;
  assign frame_end = enable && (&cnt);
  assign due = frame_end && rep_cnt == RW'(REPEAT - 1);
  assign empty = fifo_level == '0;
  assign pop = due && !empty;
  assign next_level = fifo_level + LW'(push) - LW'(pop);
  assign s.s_ready = ready;
  assign AUD_PWM = pwm_lvl ? 1'bz : 1'b0;
  // sample storage; contents are meaningless once the pointers are reset
  always_ff @(posedge HCLK)
    if (push) mem[wr_ptr] <= s.s_data;
  // FIFO pointers, level and a registered ready derived from the next level
  always_ff @(posedge HCLK or posedge HRESET)
    if (HRESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fifo_level <= '0;
      ready <= 1'b1;
    end else begin
      wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
      fifo_level <= next_level;
      ready <= next_level != LW'(FIFO_DEPTH);
    end
  // frame counters, duty update at frame end, PWM compare and sticky underrun
  always_ff @(posedge HCLK or posedge HRESET)
    if (HRESET) begin
      cnt <= '0;
      rep_cnt <= '0;
      duty <= '0;
      pwm_lvl <= 1'b0;
      AUD_SD <= 1'b0;
      underrun <= 1'b0;
    end else begin
      AUD_SD <= enable;
      pwm_lvl <= enable && cnt < duty;
      cnt <= enable ? cnt + 1'b1 : '0;
      rep_cnt <= (!enable || due) ? '0 : frame_end ? rep_cnt + 1'b1 : rep_cnt;
      duty <= pop ? mem[rd_ptr] : duty;
      underrun <= (due && empty) ? 1'b1 : underrun_clr ? 1'b0 : underrun;
    end
endmodule

// File: tb/tb_audio_pwm_out.sv
// tb_audio_pwm_out: two instances (REPEAT 1 and 3) against a queue-based frame model
module tb_audio_pwm_out;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, clr = 1'b0, valid = 1'b0;
  logic [7:0] data = 8'h00;
  always #5 clk = ~clk;
  audio_pwm_out_if #(.SAMPLE_W(8)) b0 ();
  audio_pwm_out_if #(.SAMPLE_W(8)) b1 ();
  assign b0.s_data = data;
  assign b0.s_valid = valid;
  assign b1.s_data = data;
  assign b1.s_valid = valid;
  wire aud0, aud1;
  pullup (aud0);
  pullup (aud1);
  logic sd0, sd1, ur0, ur1;
  logic [2:0] lv0, lv1;
  audio_pwm_out #(.SAMPLE_W(8), .FIFO_DEPTH(4), .REPEAT(1)) d0 (
    .HCLK(clk), .HRESET(rst), .enable(en), .s(b0), .underrun_clr(clr),
    .underrun(ur0), .fifo_level(lv0), .AUD_PWM(aud0), .AUD_SD(sd0));
  audio_pwm_out #(.SAMPLE_W(8), .FIFO_DEPTH(4), .REPEAT(3)) d1 (
    .HCLK(clk), .HRESET(rst), .enable(en), .s(b1), .underrun_clr(clr),
    .underrun(ur1), .fifo_level(lv1), .AUD_PWM(aud1), .AUD_SD(sd1));
  logic [7:0] mq [2][$];
  int t [2];
  int duty [2];
  bit mur [2];
  bit mpwm [2];
  bit msd;
  int checks = 0, failures = 0;
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mq[i].delete();
      t[i] = 0;
      duty[i] = 0;
      mur[i] = 0;
      mpwm[i] = 0;
    end
    msd = 0;
  endtask
  task automatic model_step();
    int r, c;
    bit push, due;
    if (rst) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 2; i++) begin
      r = (i == 0) ? 1 : 3;
      c = t[i] % 256;
      push = valid && mq[i].size() < 4;
      due = en && c == 255 && (t[i] / 256) % r == r - 1;
      mpwm[i] = en && c < duty[i];
      if (due && mq[i].size() > 0) duty[i] = mq[i].pop_front();
      else if (due) mur[i] = 1;
      else if (clr) mur[i] = 0;
      if (push) mq[i].push_back(data);
      t[i] = en ? t[i] + 1 : 0;
    end
    msd = en;
  endtask
  task automatic check_all();
    chk("aud0", aud0, mpwm[0]);
    chk("aud1", aud1, mpwm[1]);
    chk("sd0", sd0, msd);
    chk("sd1", sd1, msd);
    chk("ready0", b0.s_ready, mq[0].size() < 4);
    chk("ready1", b1.s_ready, mq[1].size() < 4);
    chk("level0", lv0, mq[0].size());
    chk("level1", lv1, mq[1].size());
    chk("underrun0", ur0, mur[0]);
    chk("underrun1", ur1, mur[1]);
  endtask
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask
  task automatic send(input logic [7:0] d);
    bit ok = 0;
    valid = 1'b1;
    data = d;
    for (int n = 0; n < 3000 && !ok; n++) begin
      ok = mq[0].size() < 4;
      tick();
    end
    chk("send_accepted", ok, 1);
  endtask
  task automatic drain();
    valid = 1'b0;
    for (int n = 0; n < 4000 && mq[0].size() != 0; n++) tick();
    chk("drained0", lv0, 0);
  endtask
  initial begin
    int hi;
    model_reset();
    repeat (10) tick();
    rst = 1'b0;
    repeat (300) tick();
    send(8'h40);
    valid = 1'b0;
    en = 1'b1;
    repeat (256) tick();
    hi = 0;
    repeat (256) begin
      tick();
      hi += int'(aud0);
    end
    chk("frame2_high", hi, 64);
    for (int k = 0; k < 5; k++) send(8'(k * 37 + 5));
    drain();
    send(8'h00);
    send(8'hFF);
    send(8'h80);
    valid = 1'b0;
    repeat (1100) tick();
    chk("underrun_seen", ur0, 1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    repeat (600) tick();
    drain();
    for (int n = 0; n < 4000 && mq[1].size() != 0; n++) tick();
    send(8'h10);
    send(8'h20);
    valid = 1'b0;
    repeat (3000) tick();
    for (int n = 0; n < 5000; n++) begin
      valid = 1'($urandom_range(0, 1));
      data = 8'($urandom);
      clr = $urandom_range(0, 63) == 0;
      if ($urandom_range(0, 1499) == 0) en = ~en;
      tick();
    end
    clr = 1'b0;
    en = 1'b1;
    drain();
    for (int n = 0; n < 300 && t[0] % 256 != 100; n++) tick();
    en = 1'b0;
    tick();
    send(8'hAA);
    send(8'h55);
    valid = 1'b0;
    tick();
    chk("queued_before_reset", lv0, 2);
    #2 rst = 1'b1;
    #1;
    chk("async_level0", lv0, 0);
    chk("async_level1", lv1, 0);
    chk("async_ready0", b0.s_ready, 1);
    chk("async_aud0", aud0, 0);
    chk("async_sd0", sd0, 0);
    model_reset();
    repeat (3) tick();
    rst = 1'b0;
    en = 1'b1;
    repeat (600) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
